wb_stage_mc: RTL and testbench

Parametrised multi-lane writeback stage for the CPU core. It registers `CH` retiring lanes from MEM, builds the final load data (sign/zero extension, LWL/LWR merge) and drives one regfile write port per lane. It also serialises every retired register write onto the single NSCSCC debug trace port through a small FIFO, and asks MEM to stall when that FIFO cannot take a full group of lanes.

---
 rtl/wb_stage_mc.sv | 212 +++++++++++++++++++++
 tb/tb_wb_stage_mc.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_mc.sv
// wb_stage_mc: CH-lane writeback register, load-data formatting and regfile write ports.
// Define WB_TRACE_EN to build the trace FIFO, the debug trace port and trace backpressure.
module wb_stage_mc #(
  parameter int CH          = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_stall_i,
  input  logic             wb_flush_i,
  input  logic [CH-1:0]    wb_valid_i,
  input  logic [4*CH-1:0]  wb_memop_i,
  input  logic [CH-1:0]    wb_wren_i,
  input  logic [5*CH-1:0]  wb_waddr_i,
  input  logic [32*CH-1:0] wb_wdata_i,
  input  logic [32*CH-1:0] wb_rt_i,
  input  logic [32*CH-1:0] wb_mem_addr_i,
  input  logic [32*CH-1:0] wb_mem_data_i,
  input  logic [32*CH-1:0] wb_pc_i,
  output logic [CH-1:0]    wb_wren_o,
  output logic [5*CH-1:0]  wb_waddr_o,
  output logic [32*CH-1:0] wb_wdata_o,
  output logic             wb_stall_o,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  logic [CH-1:0]    r_valid, r_wren;
  logic [4*CH-1:0]  r_memop;
  logic [5*CH-1:0]  r_waddr;
  logic [32*CH-1:0] r_wdata, r_rt, r_mdata;
  logic [2*CH-1:0]  r_addr;
  logic             r_done;
  logic [CH-1:0]    commit;
  logic [2*CH-1:0]  addr_lo;
  logic             unused_addr_hi;

  // Only the byte offset of the effective address matters to load formatting.
  always_comb begin
    addr_lo        = '0;
    unused_addr_hi = 1'b0;
    for (int i = 0; i < CH; i++) begin
      addr_lo[2*i +: 2] = wb_mem_addr_i[32*i +: 2];
      unused_addr_hi    = unused_addr_hi ^ (^wb_mem_addr_i[32*i+2 +: 30]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_wren  <= '0;
      r_memop <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rt    <= '0;
      r_mdata <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else if (wb_flush_i) begin
      r_valid <= '0;
    end else if (wb_stall_i) begin
      r_done  <= 1'b1;
    end else begin
      r_valid <= wb_valid_i;
      r_wren  <= wb_wren_i;
      r_memop <= wb_memop_i;
      r_waddr <= wb_waddr_i;
      r_wdata <= wb_wdata_i;
      r_rt    <= wb_rt_i;
      r_mdata <= wb_mem_data_i;
      r_addr  <= addr_lo;
      r_done  <= 1'b0;
    end
  end

  function automatic logic [31:0] load_data(input logic [3:0]  op,
                                            input logic [1:0]  a,
                                            input logic [31:0] m,
                                            input logic [31:0] rt,
                                            input logic [31:0] alu);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = m[{a, 3'b000} +: 8];
    h = a[1] ? m[31:16] : m[15:0];
    case (op)
      4'd1: res = {{24{b[7]}}, b};
      4'd2: res = {24'd0, b};
      4'd3: res = {{16{h[15]}}, h};
      4'd4: res = {16'd0, h};
      4'd5: res = m;
      4'd6:
        case (a)
          2'd0:    res = {m[7:0], rt[23:0]};
          2'd1:    res = {m[15:0], rt[15:0]};
          2'd2:    res = {m[23:0], rt[7:0]};
          default: res = m;
        endcase
      4'd7:
        case (a)
          2'd0:    res = m;
          2'd1:    res = {rt[31:24], m[31:8]};
          2'd2:    res = {rt[31:16], m[31:16]};
          default: res = {rt[31:8], m[31:24]};
        endcase
      default: res = alu;
    endcase
    return res;
  endfunction

  always_comb begin
    commit = '0;
    for (int i = 0; i < CH; i++)
      commit[i] = r_valid[i] && r_wren[i] && (r_waddr[5*i +: 5] != 5'd0) && !r_done;
  end

  // A younger lane writing the same register makes the older regfile write redundant.
  always_comb begin
    wb_wren_o = commit;
    for (int i = 0; i < CH; i++)
      for (int j = i + 1; j < CH; j++)
        if (commit[i] && commit[j] && (r_waddr[5*j +: 5] == r_waddr[5*i +: 5]))
          wb_wren_o[i] = 1'b0;
  end

  always_comb begin
    wb_wdata_o = '0;
    for (int i = 0; i < CH; i++)
      wb_wdata_o[32*i +: 32] = load_data(r_memop[4*i +: 4], r_addr[2*i +: 2],
                                         r_mdata[32*i +: 32], r_rt[32*i +: 32],
                                         r_wdata[32*i +: 32]);
  end

  assign wb_waddr_o = r_waddr;

`ifdef WB_TRACE_EN
  localparam int          PW      = $clog2(TRACE_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(TRACE_DEPTH);
  localparam logic [PW:0] GROUP_C = (PW+1)'(2*CH);

  logic [32*CH-1:0] r_pc;
  logic [31:0]      pc_mem   [TRACE_DEPTH];
  logic [4:0]       wnum_mem [TRACE_DEPTH];
  logic [31:0]      data_mem [TRACE_DEPTH];
  logic [PW:0]      count, n_push, free_slots;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW-1:0]    slot [CH];
  logic             pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc <= '0;
    else if (!wb_flush_i && !wb_stall_i)
      r_pc <= wb_pc_i;
  end

  // Committing lanes take consecutive slots in program order.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < CH; i++) begin
      slot[i] = wr_ptr + n_push[PW-1:0];
      n_push  = n_push + {{PW{1'b0}}, commit[i]};
    end
  end

  assign pop        = (count != '0);
  assign free_slots = DEPTH_C - count;
  assign wb_stall_o = (free_slots < GROUP_C);

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (commit[i]) begin
        pc_mem[slot[i]]   <= r_pc[32*i +: 32];
        wnum_mem[slot[i]] <= r_waddr[5*i +: 5];
        data_mem[slot[i]] <= wb_wdata_o[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, pop};
      count  <= count + n_push - {{PW{1'b0}}, pop};
    end
  end

  assign debug_wb_pc       = pop ? pc_mem[rd_ptr]   : 32'd0;
  assign debug_wb_rf_wen   = pop ? 4'hf             : 4'h0;
  assign debug_wb_rf_wnum  = pop ? wnum_mem[rd_ptr] : 5'd0;
  assign debug_wb_rf_wdata = pop ? data_mem[rd_ptr] : 32'd0;

  a_trace_no_overflow: assert property (@(posedge clk) disable iff (rst) n_push <= free_slots);
`else
  localparam int unused_trace_depth = TRACE_DEPTH;
  logic unused_pc;

  assign unused_pc         = ^wb_pc_i;
  assign wb_stall_o        = 1'b0;
  assign debug_wb_pc       = 32'd0;
  assign debug_wb_rf_wen   = 4'h0;
  assign debug_wb_rf_wnum  = 5'd0;
  assign debug_wb_rf_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage_mc.sv
// tb_wb_stage_mc: scoreboard bench for wb_stage_mc; directed boundary cases then random traffic.
// Trace-port expectations are only built when WB_TRACE_EN is defined for the compile.
module tb_wb_stage_mc;
  localparam int CH    = 2;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst;
  logic             wb_stall_i, wb_flush_i;
  logic [CH-1:0]    wb_valid_i, wb_wren_i;
  logic [4*CH-1:0]  wb_memop_i;
  logic [5*CH-1:0]  wb_waddr_i;
  logic [32*CH-1:0] wb_wdata_i, wb_rt_i, wb_mem_addr_i, wb_mem_data_i, wb_pc_i;
  logic [CH-1:0]    wb_wren_o;
  logic [5*CH-1:0]  wb_waddr_o;
  logic [32*CH-1:0] wb_wdata_o;
  logic             wb_stall_o;
  logic [31:0]      debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;

  wb_stage_mc #(.CH(CH), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_stall_i(wb_stall_i), .wb_flush_i(wb_flush_i),
    .wb_valid_i(wb_valid_i), .wb_memop_i(wb_memop_i), .wb_wren_i(wb_wren_i),
    .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_rt_i(wb_rt_i),
    .wb_mem_addr_i(wb_mem_addr_i), .wb_mem_data_i(wb_mem_data_i), .wb_pc_i(wb_pc_i),
    .wb_wren_o(wb_wren_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .wb_stall_o(wb_stall_o), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]    wren;
    logic [5*CH-1:0]  waddr;
    logic [32*CH-1:0] wdata;
  } rf_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] data;
  } tr_exp_t;

  rf_exp_t     exp_rf[$];
  tr_exp_t     exp_tr[$];
  int          n_tests, n_fail, n_trace_seen;
  bit          mon_en;
  logic [31:0] pc_ctr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference load formatting from shifts and masks over the raw word.
  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] m, input logic [31:0] rt,
                                           input logic [31:0] alu);
    int          sh, shl;
    logic [31:0] b, h;
    sh  = 8 * int'(a);
    shl = 24 - sh;
    b   = (m >> sh) & 32'hff;
    h   = (m >> (a[1] ? 16 : 0)) & 32'hffff;
    case (op)
      4'd1:    return (b ^ 32'h80) - 32'h80;
      4'd2:    return b;
      4'd3:    return (h ^ 32'h8000) - 32'h8000;
      4'd4:    return h;
      4'd5:    return m;
      4'd6:    return (m << shl) | (rt & ((32'd1 << shl) - 32'd1));
      4'd7:    return (m >> sh) | (rt & ~(32'hffffffff >> sh));
      default: return alu;
    endcase
  endfunction

  task automatic clear_inputs();
    wb_stall_i = 1'b0; wb_flush_i = 1'b0;
    wb_valid_i = '0; wb_wren_i = '0; wb_memop_i = '0; wb_waddr_i = '0;
    wb_wdata_i = '0; wb_rt_i = '0; wb_mem_addr_i = '0; wb_mem_data_i = '0; wb_pc_i = '0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [3:0] op, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] rt,
                          input logic [31:0] ad, input logic [31:0] md);
    wb_valid_i[i]             = v;
    wb_memop_i[4*i +: 4]      = op;
    wb_wren_i[i]              = we;
    wb_waddr_i[5*i +: 5]      = wa;
    wb_wdata_i[32*i +: 32]    = wd;
    wb_rt_i[32*i +: 32]       = rt;
    wb_mem_addr_i[32*i +: 32] = ad;
    wb_mem_data_i[32*i +: 32] = md;
    wb_pc_i[32*i +: 32]       = pc_ctr;
    pc_ctr                    = pc_ctr + 32'd4;
  endtask

  // Record what the current inputs should produce once captured, then advance one cycle.
  task automatic issue();
    rf_exp_t       e;
    logic [CH-1:0] c;
    logic [31:0]   d;
    e.wren = '0; e.waddr = wb_waddr_i; e.wdata = '0; c = '0;
    if (!wb_flush_i && !wb_stall_i) begin
      for (int i = 0; i < CH; i++)
        c[i] = wb_valid_i[i] && wb_wren_i[i] && (wb_waddr_i[5*i +: 5] != 5'd0);
      for (int i = 0; i < CH; i++) begin
        if (c[i]) begin
          d = ref_load(wb_memop_i[4*i +: 4], wb_mem_addr_i[32*i +: 2], wb_mem_data_i[32*i +: 32],
                       wb_rt_i[32*i +: 32], wb_wdata_i[32*i +: 32]);
          e.wdata[32*i +: 32] = d;
          e.wren[i] = 1'b1;
          for (int j = i + 1; j < CH; j++)
            if (c[j] && (wb_waddr_i[5*j +: 5] == wb_waddr_i[5*i +: 5])) e.wren[i] = 1'b0;
`ifdef WB_TRACE_EN
          exp_tr.push_back('{pc: wb_pc_i[32*i +: 32], wnum: wb_waddr_i[5*i +: 5], data: d});
`endif
        end
      end
    end
    exp_rf.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) issue();
  endtask

  task automatic prime();
    rf_exp_t e;
    e.wren = '0; e.waddr = '0; e.wdata = '0;
    exp_rf.push_back(e);
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rf_exp_t e;
      tr_exp_t t;
      if (exp_rf.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rf_queue: DUT wren 0x%0h with no expectation queued", wb_wren_o);
      end else begin
        e = exp_rf.pop_front();
        check("rf_wren", 64'(wb_wren_o), 64'(e.wren));
        for (int i = 0; i < CH; i++) begin
          if (e.wren[i]) begin
            check("rf_waddr", 64'(wb_waddr_o[5*i +: 5]), 64'(e.waddr[5*i +: 5]));
            check("rf_wdata", 64'(wb_wdata_o[32*i +: 32]), 64'(e.wdata[32*i +: 32]));
          end
        end
      end
`ifdef WB_TRACE_EN
      if (debug_wb_rf_wen != 4'h0) begin
        n_trace_seen++;
        check("tr_wen", 64'(debug_wb_rf_wen), 64'hf);
        if (exp_tr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tr_extra: pc 0x%0h wnum %0d with no expected entry", debug_wb_pc, debug_wb_rf_wnum);
        end else begin
          t = exp_tr.pop_front();
          check("tr_pc", 64'(debug_wb_pc), 64'(t.pc));
          check("tr_wnum", 64'(debug_wb_rf_wnum), 64'(t.wnum));
          check("tr_wdata", 64'(debug_wb_rf_wdata), 64'(t.data));
        end
      end else begin
        check("tr_idle", 64'({debug_wb_pc, debug_wb_rf_wnum}), 64'h0);
        check("tr_idle_data", 64'(debug_wb_rf_wdata), 64'h0);
      end
`else
      check("dbg_off", 64'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 64'h0);
      check("dbg_off_pc", 64'({debug_wb_pc, wb_stall_o}), 64'h0);
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, guard;
    n_tests = 0; n_fail = 0; n_trace_seen = 0; mon_en = 1'b0; pc_ctr = 32'h0000_1000;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_wren", 64'(wb_wren_o), 64'h0);
    check("rst_wdata", 64'(wb_wdata_o), 64'h0);
    check("rst_waddr_stall", 64'({wb_waddr_o, wb_stall_o}), 64'h0);
    check("rst_dbg", 64'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 64'h0);
    check("rst_dbg_pc", 64'(debug_wb_pc), 64'h0);
    prime();

    // LB sign extension, then trace visibility one cycle later
    clear_inputs();
    set_lane(0, 1'b1, 4'd1, 1'b1, 5'd5, 32'hdead_beef, 32'h0, 32'h0000_0102, 32'h1280_3456);
    issue();
    check("lb_wdata", 64'(wb_wdata_o[31:0]), 64'hffff_ff80);
    check("lb_wren", 64'(wb_wren_o), 64'h1);
    idle(1);
`ifdef WB_TRACE_EN
    check("lb_trace_wnum", 64'(debug_wb_rf_wnum), 64'd5);
    check("lb_trace_data", 64'(debug_wb_rf_wdata), 64'hffff_ff80);
`endif
    idle(3);

    // LWL on lane 0, LWR on lane 1
    clear_inputs();
    set_lane(0, 1'b1, 4'd6, 1'b1, 5'd9, 32'h0, 32'h1122_3344, 32'h1, 32'haabb_ccdd);
    set_lane(1, 1'b1, 4'd7, 1'b1, 5'd10, 32'h0, 32'h1122_3344, 32'h2, 32'haabb_ccdd);
    issue();
    check("lwl_wdata", 64'(wb_wdata_o[31:0]), 64'hccdd_3344);
    check("lwr_wdata", 64'(wb_wdata_o[63:32]), 64'h1122_aabb);
    check("lwlr_wren", 64'(wb_wren_o), 64'h3);
    idle(4);

    // Same destination: only the younger lane writes, trace keeps both in order
    clear_inputs();
    set_lane(0, 1'b1, 4'd0, 1'b1, 5'd8, 32'h1, 32'h0, 32'h0, 32'h0);
    set_lane(1, 1'b1, 4'd9, 1'b1, 5'd8, 32'h2, 32'h0, 32'h0, 32'h0);
    issue();
    check("samedst_wren", 64'(wb_wren_o), 64'h2);
    idle(1);
`ifdef WB_TRACE_EN
    check("samedst_tr_first", 64'(debug_wb_rf_wdata), 64'h1);
`endif
    idle(1);
`ifdef WB_TRACE_EN
    check("samedst_tr_second", 64'(debug_wb_rf_wdata), 64'h2);
`endif
    idle(3);

    // Stall hold: one write and one trace entry despite three held cycles
    seen = n_trace_seen;
    clear_inputs();
    set_lane(0, 1'b1, 4'd0, 1'b1, 5'd12, 32'h55, 32'h0, 32'h0, 32'h0);
    issue();
    wb_stall_i = 1'b1;
    repeat (3) issue();
    idle(4);
`ifdef WB_TRACE_EN
    check("stall_one_trace", 64'(n_trace_seen - seen), 64'd1);
`endif

    // Flush and stall together on a fresh load: nothing may write
    clear_inputs();
    set_lane(0, 1'b1, 4'd0, 1'b1, 5'd13, 32'h77, 32'h0, 32'h0, 32'h0);
    wb_flush_i = 1'b1; wb_stall_i = 1'b1;
    issue();
    idle(4);

    // Backpressure: five dual-lane commits against an eight-entry FIFO
    for (int k = 0; k < 5; k++) begin
`ifdef WB_TRACE_EN
      check("bp_low_before", 64'(wb_stall_o), 64'h0);
`endif
      clear_inputs();
      set_lane(0, 1'b1, 4'd0, 1'b1, 5'(16 + 2*k), 32'h100 + 32'(k), 32'h0, 32'h0, 32'h0);
      set_lane(1, 1'b1, 4'd0, 1'b1, 5'(17 + 2*k), 32'h200 + 32'(k), 32'h0, 32'h0, 32'h0);
      issue();
    end
`ifdef WB_TRACE_EN
    check("bp_stall_high", 64'(wb_stall_o), 64'h1);
`endif

    // Reset mid-drain with three entries still queued
    clear_inputs();
    guard = 0;
    while (exp_tr.size() > 3 && guard < 50) begin
      issue();
      guard++;
    end
`ifdef WB_TRACE_EN
    check("drain_to_three", 64'(exp_tr.size()), 64'd3);
    check("pre_rst_wen", 64'(debug_wb_rf_wen), 64'hf);
`endif
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_dbg", 64'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 64'h0);
    check("midrst_pc_stall", 64'({debug_wb_pc, wb_stall_o}), 64'h0);
    check("midrst_wren", 64'(wb_wren_o), 64'h0);
    exp_rf.delete();
    exp_tr.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    prime();

    // Random traffic that honours backpressure
    for (int k = 0; k < 400; k++) begin
      logic bp;
      bp = wb_stall_o;
      clear_inputs();
      wb_flush_i = ($urandom_range(0, 19) == 0);
      wb_stall_i = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < CH; i++)
        set_lane(i, !bp && ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, $urandom);
      issue();
    end

    clear_inputs();
    guard = 0;
    while (exp_tr.size() != 0 && guard < 64) begin
      issue();
      guard++;
    end
    check("final_trace_drained", 64'(exp_tr.size()), 64'd0);
    @(negedge clk);
    #1 mon_en = 1'b0;
    check("final_rf_drained", 64'(exp_rf.size()), 64'd0);
    check("final_stall_low", 64'(wb_stall_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
